mmcm_dyn_reconf: RTL and testbench
==================================

// Module: mmcm_dyn_reconf
// PURPOSE
//  DRP (dynamic reconfiguration port) register model for a behavioural MMCM simulation model.
//  - Holds a 128 x 16-bit register file written and read over the DRP.
//  - Decodes the clock registers into the divide, duty-cycle and phase values used by the PLL core.
//  - Sits between the DRP master and the MMCM clock-generation logic.
// PARAMETERS
//  none; addresses and field positions are package constants.
// PORTS
//  DCLK                     in   1   DRP clock; the only clock in the block.
//  RST                      in   1   reset, synchronous, active-low (0 = reset).
//  PWRDWN                   in   1   1 = DRP writes ignored; reads still work.
//  vco_period_1000          in   33  VCO period x1000 (e.g. 32000 = period 32).
//  DADDR                    in   7   DRP register address.
//  DEN                      in   1   DRP access enable.
//  DWE                      in   1   DRP write enable; qualified by DEN.
//  DI                       in   16  DRP write data.
//  DO                       out  16  DRP read data (registered).
//  DRDY                     out  1   DRP ready (registered).
//  CLKOUTn_DIVIDE           out  32  n=0..6: decoded output divide.
//  CLKOUTn_DUTY_CYCLE_1000  out  32  n=0..6: duty cycle x1000.
//  CLKOUTn_PHASE            out  32  n=0..6: phase offset, in units of vco_period_1000/1000.
//  CLKFBOUT_MULT            out  32  feedback multiplier.
//  CLKFBOUT_PHASE           out  32  feedback phase, same units as CLKOUTn_PHASE.
//  DIVCLK_DIVIDE            out  32  input divider.
// BEHAVIOUR
//  Reset (DCLK edge with RST=0):
//   - All 128 registers cleared to 0.
//   - DO = 16'h0000, DRDY = 1.
//  Every DCLK edge when RST=1:
//   - DRDY <= ~DEN.
//   - if DEN & DWE & ~PWRDWN: mem[DADDR] <= DI.
//   - if DEN & ~DWE: DO <= mem[DADDR].
//   - otherwise DO holds.
//  Register pairs (Reg1, Reg2):
//   - CLKOUT5 06/07, CLKOUT0 08/09, CLKOUT1 0A/0B, CLKOUT2 0C/0D.
//   - CLKOUT3 0E/0F, CLKOUT4 10/11, CLKOUT6 12/13, CLKFBOUT 14/15.
//   - DIVCLK single register 16.
//   - All other addresses are plain storage.
//  Reg1 fields: [15:13] PHASE_MUX, [12] reserved, [11:6] HIGH, [5:0] LOW.
//  Reg2 fields: [15] rsvd, [14:12] FRAC, [11] FRAC_EN, [10] FRAC_WF_R, [9:8] MX, [7] EDGE, [6] NO_COUNT, [5:0] DELAY.
//   - FRAC, FRAC_EN, FRAC_WF_R and MX are stored only and ignored by the decode.
//  DIVCLK reg (16): [13] EDGE, [12] NO_COUNT, [11:6] HIGH, [5:0] LOW.
//  Decode (combinational from registers):
//   - h = (HIGH==0) ? 64 : HIGH; l = (LOW==0) ? 64 : LOW; T = h + l.
//   - DIVIDE / MULT = NO_COUNT ? 1 : T.
//   - DUTY_1000 = NO_COUNT ? 500 : ((2h + EDGE)*1000 + T) / (2T), integer; equals round(1000*h/T) when EDGE=0.
//   - PHASE = vco_period_1000 * (PHASE_MUX + 8*DELAY) / 8000; 64-bit intermediate, truncated.
//  Reset outputs (all registers 0): every DIVIDE/MULT = 128, DUTY = 500, PHASE = 0.
//  Boundary conditions:
//   - RST=0 mid-access wins and clears everything.
//   - A write followed by a read of the same address returns the new value.
//   - vco_period_1000 changes propagate to PHASE outputs combinationally.
// STRUCTURE
//  Package mmcm_drp_pkg:
//   - address localparams for all register pairs;
//   - Reg1/Reg2/DIVCLK field bit positions;
//   - the 64-count-on-zero rule.
//  Sub-module mmcm_clkreg_decode: Reg1, Reg2 and vco_period_1000 -> DIVIDE, DUTY_1000, PHASE.
//   - Instantiated 8 times: CLKOUT0..6 and CLKFBOUT.
//   - DIVCLK decode is inline.
// TESTING
//  1. RST=0 for 2 DCLK cycles -> DO=0000, DRDY=1; release -> DRDY stays 1.
//  2. Write 0x08 <= 16'b011_0_000110_000011 -> DRDY=0 while DEN=1; DRDY=1 one cycle after DEN drops.
//  3. Read 0x08 -> DO=0x6183, DRDY=0; CLKOUT0_DIVIDE=9, DUTY=667, PHASE=12 (vco_period_1000=32000).
//  4. Then write 0x09 <= 16'h0043 (NO_COUNT=1, DELAY=3) -> CLKOUT0_DIVIDE=1, DUTY=500, PHASE=108.
//  5. Write 0x16 with PWRDWN=1, then read 0x16 -> DO=0000 (write ignored); repeat with PWRDWN=0 -> DO=DI.
//  6. Write 0x14 <= 16'h0145 (HIGH=5, LOW=5) -> CLKFBOUT_MULT=10, other outputs unchanged.

Source files
------------

// File: rtl/mmcm_drp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmcm_drp_pkg
//  Description : DRP register map, field positions and counter helpers shared
//                by the MMCM dynamic-reconfiguration register model.
//  Revision    : 1.0 - initial release
// ============================================================================
package mmcm_drp_pkg;

    localparam int c_addr_w  = 7;
    localparam int c_data_w  = 16;
    localparam int c_depth   = 128;
    localparam int c_count_w = 6;
    localparam int c_num_dec = 8;   // CLKOUT0..6 followed by CLKFBOUT

    localparam logic [c_addr_w-1:0] c_addr_clkout5_reg1  = 7'h06;
    localparam logic [c_addr_w-1:0] c_addr_clkout0_reg1  = 7'h08;
    localparam logic [c_addr_w-1:0] c_addr_clkout1_reg1  = 7'h0A;
    localparam logic [c_addr_w-1:0] c_addr_clkout2_reg1  = 7'h0C;
    localparam logic [c_addr_w-1:0] c_addr_clkout3_reg1  = 7'h0E;
    localparam logic [c_addr_w-1:0] c_addr_clkout4_reg1  = 7'h10;
    localparam logic [c_addr_w-1:0] c_addr_clkout6_reg1  = 7'h12;
    localparam logic [c_addr_w-1:0] c_addr_clkfbout_reg1 = 7'h14;
    localparam logic [c_addr_w-1:0] c_addr_divclk        = 7'h16;

    localparam int c_reg1_phase_mux_lsb   = 13;
    localparam int c_reg1_high_lsb        = 6;
    localparam int c_reg1_low_lsb         = 0;
    localparam int c_reg2_edge_bit        = 7;
    localparam int c_reg2_no_count_bit    = 6;
    localparam int c_reg2_delay_lsb       = 0;
    localparam int c_divclk_no_count_bit  = 12;
    localparam int c_divclk_high_lsb      = 6;
    localparam int c_divclk_low_lsb       = 0;

    // A zero count field means a full 64-cycle count.
    function automatic logic [6:0] count_or_64(input logic [c_count_w-1:0] field);
        return (field == '0) ? 7'd64 : {1'b0, field};
    endfunction

    function automatic logic [c_addr_w-1:0] reg1_addr(input int idx);
        case (idx)
            0:       return c_addr_clkout0_reg1;
            1:       return c_addr_clkout1_reg1;
            2:       return c_addr_clkout2_reg1;
            3:       return c_addr_clkout3_reg1;
            4:       return c_addr_clkout4_reg1;
            5:       return c_addr_clkout5_reg1;
            6:       return c_addr_clkout6_reg1;
            default: return c_addr_clkfbout_reg1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmcm_clkreg_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mmcm_clkreg_decode
//  Description : Turns one Reg1/Reg2 clock register pair into divide, duty
//                cycle (x1000) and phase offset for the clock core.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmcm_clkreg_decode
    import mmcm_drp_pkg::*;
(
    input  logic [15:0] i_reg1,
    input  logic [15:0] i_reg2,
    input  logic [32:0] i_vco_period_1000,
    output logic [31:0] o_divide,
    output logic [31:0] o_duty_1000,
    output logic [31:0] o_phase
);

    logic [6:0]  w_h;
    logic [6:0]  w_l;
    logic [7:0]  w_t;
    logic        w_no_count;
    logic [31:0] w_num;
    logic [31:0] w_den;
    logic [63:0] w_steps;
    logic [63:0] w_phase_full;
    logic        w_unused;

    assign w_h        = count_or_64(i_reg1[c_reg1_high_lsb +: c_count_w]);
    assign w_l        = count_or_64(i_reg1[c_reg1_low_lsb  +: c_count_w]);
    assign w_t        = 8'(w_h) + 8'(w_l);
    assign w_no_count = i_reg2[c_reg2_no_count_bit];

    // Adding T before dividing by 2T rounds the duty to the nearest 1/1000.
    assign w_num = (32'(w_h) * 32'd2 + 32'(i_reg2[c_reg2_edge_bit])) * 32'd1000 + 32'(w_t);
    assign w_den = 32'(w_t) * 32'd2;

    assign o_divide    = w_no_count ? 32'd1   : 32'(w_t);
    assign o_duty_1000 = w_no_count ? 32'd500 : w_num / w_den;

    // Phase in eighths of a VCO period: PHASE_MUX plus 8 per DELAY step.
    assign w_steps      = 64'(i_reg1[c_reg1_phase_mux_lsb +: 3])
                        + 64'(i_reg2[c_reg2_delay_lsb +: c_count_w]) * 64'd8;
    assign w_phase_full = (64'(i_vco_period_1000) * w_steps) / 64'd8000;
    assign o_phase      = w_phase_full[31:0];

    assign w_unused = ^{i_reg1[12], i_reg2[15:8], w_phase_full[63:32]};

endmodule
`default_nettype wire

// File: rtl/mmcm_dyn_reconf.sv
`default_nettype none
// ============================================================================
//  Module      : mmcm_dyn_reconf
//  Description : DRP register file for a behavioural MMCM model, with the
//                clock registers decoded into divide/duty/phase values.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmcm_dyn_reconf
    import mmcm_drp_pkg::*;
(
    input  logic                DCLK,
    input  logic                RST,
    input  logic                PWRDWN,
    input  logic [32:0]         vco_period_1000,
    input  logic [c_addr_w-1:0] DADDR,
    input  logic                DEN,
    input  logic                DWE,
    input  logic [c_data_w-1:0] DI,
    output logic [c_data_w-1:0] DO,
    output logic                DRDY,
    output logic [31:0]         CLKOUT0_DIVIDE,
    output logic [31:0]         CLKOUT1_DIVIDE,
    output logic [31:0]         CLKOUT2_DIVIDE,
    output logic [31:0]         CLKOUT3_DIVIDE,
    output logic [31:0]         CLKOUT4_DIVIDE,
    output logic [31:0]         CLKOUT5_DIVIDE,
    output logic [31:0]         CLKOUT6_DIVIDE,
    output logic [31:0]         CLKOUT0_DUTY_CYCLE_1000,
    output logic [31:0]         CLKOUT1_DUTY_CYCLE_1000,
    output logic [31:0]         CLKOUT2_DUTY_CYCLE_1000,
    output logic [31:0]         CLKOUT3_DUTY_CYCLE_1000,
    output logic [31:0]         CLKOUT4_DUTY_CYCLE_1000,
    output logic [31:0]         CLKOUT5_DUTY_CYCLE_1000,
    output logic [31:0]         CLKOUT6_DUTY_CYCLE_1000,
    output logic [31:0]         CLKOUT0_PHASE,
    output logic [31:0]         CLKOUT1_PHASE,
    output logic [31:0]         CLKOUT2_PHASE,
    output logic [31:0]         CLKOUT3_PHASE,
    output logic [31:0]         CLKOUT4_PHASE,
    output logic [31:0]         CLKOUT5_PHASE,
    output logic [31:0]         CLKOUT6_PHASE,
    output logic [31:0]         CLKFBOUT_MULT,
    output logic [31:0]         CLKFBOUT_PHASE,
    output logic [31:0]         DIVCLK_DIVIDE
);

    logic [c_data_w-1:0] r_mem [c_depth];
    logic [c_data_w-1:0] r_do;
    logic                r_drdy;
    logic [31:0]         w_divide [c_num_dec];
    logic [31:0]         w_duty   [c_num_dec];
    logic [31:0]         w_phase  [c_num_dec];
    logic [7:0]          w_divclk_t;

    always_ff @(posedge DCLK) begin
        if (!RST) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
            r_do   <= '0;
            r_drdy <= 1'b1;
        end else begin
            r_drdy <= ~DEN;
            if (DEN && DWE && !PWRDWN) begin
                r_mem[DADDR] <= DI;
            end
            if (DEN && !DWE) begin
                r_do <= r_mem[DADDR];
            end
        end
    end

    assign DO   = r_do;
    assign DRDY = r_drdy;

    for (genvar gi = 0; gi < c_num_dec; gi++) begin : g_dec
        localparam logic [c_addr_w-1:0] c_a = reg1_addr(gi);
        mmcm_clkreg_decode u_decode (
            .i_reg1            (r_mem[c_a]),
            .i_reg2            (r_mem[c_a + 7'd1]),
            .i_vco_period_1000 (vco_period_1000),
            .o_divide          (w_divide[gi]),
            .o_duty_1000       (w_duty[gi]),
            .o_phase           (w_phase[gi])
        );
    end

    assign w_divclk_t    = 8'(count_or_64(r_mem[c_addr_divclk][c_divclk_high_lsb +: c_count_w]))
                         + 8'(count_or_64(r_mem[c_addr_divclk][c_divclk_low_lsb  +: c_count_w]));
    assign DIVCLK_DIVIDE = r_mem[c_addr_divclk][c_divclk_no_count_bit] ? 32'd1 : 32'(w_divclk_t);

    assign CLKOUT0_DIVIDE          = w_divide[0];
    assign CLKOUT1_DIVIDE          = w_divide[1];
    assign CLKOUT2_DIVIDE          = w_divide[2];
    assign CLKOUT3_DIVIDE          = w_divide[3];
    assign CLKOUT4_DIVIDE          = w_divide[4];
    assign CLKOUT5_DIVIDE          = w_divide[5];
    assign CLKOUT6_DIVIDE          = w_divide[6];
    assign CLKFBOUT_MULT           = w_divide[7];
    assign CLKOUT0_DUTY_CYCLE_1000 = w_duty[0];
    assign CLKOUT1_DUTY_CYCLE_1000 = w_duty[1];
    assign CLKOUT2_DUTY_CYCLE_1000 = w_duty[2];
    assign CLKOUT3_DUTY_CYCLE_1000 = w_duty[3];
    assign CLKOUT4_DUTY_CYCLE_1000 = w_duty[4];
    assign CLKOUT5_DUTY_CYCLE_1000 = w_duty[5];
    assign CLKOUT6_DUTY_CYCLE_1000 = w_duty[6];
    assign CLKOUT0_PHASE           = w_phase[0];
    assign CLKOUT1_PHASE           = w_phase[1];
    assign CLKOUT2_PHASE           = w_phase[2];
    assign CLKOUT3_PHASE           = w_phase[3];
    assign CLKOUT4_PHASE           = w_phase[4];
    assign CLKOUT5_PHASE           = w_phase[5];
    assign CLKOUT6_PHASE           = w_phase[6];
    assign CLKFBOUT_PHASE          = w_phase[7];

endmodule
`default_nettype wire

// File: tb/tb_mmcm_dyn_reconf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmcm_dyn_reconf
//  Description : Self-checking bench for the MMCM DRP register model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmcm_dyn_reconf;

    logic        DCLK = 1'b0;
    logic        RST, PWRDWN, DEN, DWE;
    logic [32:0] vco_period_1000;
    logic [6:0]  DADDR;
    logic [15:0] DI, DO;
    logic        DRDY;
    logic [31:0] CLKOUT0_DIVIDE, CLKOUT1_DIVIDE, CLKOUT2_DIVIDE, CLKOUT3_DIVIDE;
    logic [31:0] CLKOUT4_DIVIDE, CLKOUT5_DIVIDE, CLKOUT6_DIVIDE;
    logic [31:0] CLKOUT0_DUTY_CYCLE_1000, CLKOUT1_DUTY_CYCLE_1000, CLKOUT2_DUTY_CYCLE_1000;
    logic [31:0] CLKOUT3_DUTY_CYCLE_1000, CLKOUT4_DUTY_CYCLE_1000, CLKOUT5_DUTY_CYCLE_1000;
    logic [31:0] CLKOUT6_DUTY_CYCLE_1000;
    logic [31:0] CLKOUT0_PHASE, CLKOUT1_PHASE, CLKOUT2_PHASE, CLKOUT3_PHASE;
    logic [31:0] CLKOUT4_PHASE, CLKOUT5_PHASE, CLKOUT6_PHASE;
    logic [31:0] CLKFBOUT_MULT, CLKFBOUT_PHASE, DIVCLK_DIVIDE;

    logic [31:0] div_o  [8];
    logic [31:0] duty_o [8];
    logic [31:0] ph_o   [8];

    logic [15:0] m_mem [128];
    int unsigned reg1_addr_tbl [8] = '{8, 10, 12, 14, 16, 6, 18, 20};
    int          n_vec = 0;
    int          n_err = 0;

    always #5 DCLK = ~DCLK;

    mmcm_dyn_reconf dut (
        .DCLK(DCLK), .RST(RST), .PWRDWN(PWRDWN), .vco_period_1000(vco_period_1000),
        .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY),
        .CLKOUT0_DIVIDE(CLKOUT0_DIVIDE), .CLKOUT1_DIVIDE(CLKOUT1_DIVIDE),
        .CLKOUT2_DIVIDE(CLKOUT2_DIVIDE), .CLKOUT3_DIVIDE(CLKOUT3_DIVIDE),
        .CLKOUT4_DIVIDE(CLKOUT4_DIVIDE), .CLKOUT5_DIVIDE(CLKOUT5_DIVIDE),
        .CLKOUT6_DIVIDE(CLKOUT6_DIVIDE),
        .CLKOUT0_DUTY_CYCLE_1000(CLKOUT0_DUTY_CYCLE_1000), .CLKOUT1_DUTY_CYCLE_1000(CLKOUT1_DUTY_CYCLE_1000),
        .CLKOUT2_DUTY_CYCLE_1000(CLKOUT2_DUTY_CYCLE_1000), .CLKOUT3_DUTY_CYCLE_1000(CLKOUT3_DUTY_CYCLE_1000),
        .CLKOUT4_DUTY_CYCLE_1000(CLKOUT4_DUTY_CYCLE_1000), .CLKOUT5_DUTY_CYCLE_1000(CLKOUT5_DUTY_CYCLE_1000),
        .CLKOUT6_DUTY_CYCLE_1000(CLKOUT6_DUTY_CYCLE_1000),
        .CLKOUT0_PHASE(CLKOUT0_PHASE), .CLKOUT1_PHASE(CLKOUT1_PHASE), .CLKOUT2_PHASE(CLKOUT2_PHASE),
        .CLKOUT3_PHASE(CLKOUT3_PHASE), .CLKOUT4_PHASE(CLKOUT4_PHASE), .CLKOUT5_PHASE(CLKOUT5_PHASE),
        .CLKOUT6_PHASE(CLKOUT6_PHASE),
        .CLKFBOUT_MULT(CLKFBOUT_MULT), .CLKFBOUT_PHASE(CLKFBOUT_PHASE), .DIVCLK_DIVIDE(DIVCLK_DIVIDE)
    );

    assign div_o[0] = CLKOUT0_DIVIDE;  assign duty_o[0] = CLKOUT0_DUTY_CYCLE_1000;  assign ph_o[0] = CLKOUT0_PHASE;
    assign div_o[1] = CLKOUT1_DIVIDE;  assign duty_o[1] = CLKOUT1_DUTY_CYCLE_1000;  assign ph_o[1] = CLKOUT1_PHASE;
    assign div_o[2] = CLKOUT2_DIVIDE;  assign duty_o[2] = CLKOUT2_DUTY_CYCLE_1000;  assign ph_o[2] = CLKOUT2_PHASE;
    assign div_o[3] = CLKOUT3_DIVIDE;  assign duty_o[3] = CLKOUT3_DUTY_CYCLE_1000;  assign ph_o[3] = CLKOUT3_PHASE;
    assign div_o[4] = CLKOUT4_DIVIDE;  assign duty_o[4] = CLKOUT4_DUTY_CYCLE_1000;  assign ph_o[4] = CLKOUT4_PHASE;
    assign div_o[5] = CLKOUT5_DIVIDE;  assign duty_o[5] = CLKOUT5_DUTY_CYCLE_1000;  assign ph_o[5] = CLKOUT5_PHASE;
    assign div_o[6] = CLKOUT6_DIVIDE;  assign duty_o[6] = CLKOUT6_DUTY_CYCLE_1000;  assign ph_o[6] = CLKOUT6_PHASE;
    assign div_o[7] = CLKFBOUT_MULT;   assign duty_o[7] = 32'd500;                  assign ph_o[7] = CLKFBOUT_PHASE;

    // Reference decode, written directly from the register field definitions.
    function automatic int unsigned m_cnt(input int unsigned f);
        return (f == 0) ? 64 : f;
    endfunction

    function automatic int unsigned m_div(input int unsigned r1, input int unsigned r2);
        if (((r2 >> 6) & 1) != 0) return 1;
        return m_cnt((r1 >> 6) & 63) + m_cnt(r1 & 63);
    endfunction

    function automatic int unsigned m_duty(input int unsigned r1, input int unsigned r2);
        int unsigned h, t;
        if (((r2 >> 6) & 1) != 0) return 500;
        h = m_cnt((r1 >> 6) & 63);
        t = h + m_cnt(r1 & 63);
        return ((2 * h + ((r2 >> 7) & 1)) * 1000 + t) / (2 * t);
    endfunction

    function automatic logic [31:0] m_phase(input int unsigned r1, input int unsigned r2,
                                            input longint unsigned vco);
        longint unsigned steps;
        steps = longint'((r1 >> 13) & 7) + 8 * longint'(r2 & 63);
        return 32'((vco * steps) / 8000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int unsigned r1, r2, d;
        for (int i = 0; i < 8; i++) begin
            r1 = m_mem[reg1_addr_tbl[i]];
            r2 = m_mem[reg1_addr_tbl[i] + 1];
            chk($sformatf("divide%0d", i), div_o[i], m_div(r1, r2));
            if (i < 7) chk($sformatf("duty%0d", i), duty_o[i], m_duty(r1, r2));
            chk($sformatf("phase%0d", i), ph_o[i], m_phase(r1, r2, longint'(vco_period_1000)));
        end
        d = m_mem[22];
        chk("divclk", DIVCLK_DIVIDE, (((d >> 12) & 1) != 0) ? 1 : m_cnt((d >> 6) & 63) + m_cnt(d & 63));
    endtask

    // Entered and left at a falling edge.
    task automatic drp_write(input logic [6:0] a, input logic [15:0] d, input logic pd);
        DADDR = a; DI = d; DEN = 1'b1; DWE = 1'b1; PWRDWN = pd;
        @(negedge DCLK);
        chk("wr_drdy_busy", 32'(DRDY), 32'd0);
        if (!pd) m_mem[a] = d;
        DEN = 1'b0; DWE = 1'b0; PWRDWN = 1'b0;
        @(negedge DCLK);
        chk("wr_drdy_idle", 32'(DRDY), 32'd1);
    endtask

    task automatic drp_read(input logic [6:0] a, input logic pd);
        DADDR = a; DEN = 1'b1; DWE = 1'b0; PWRDWN = pd;
        @(negedge DCLK);
        chk("rd_do", 32'(DO), 32'(m_mem[a]));
        chk("rd_drdy_busy", 32'(DRDY), 32'd0);
        DEN = 1'b0; PWRDWN = 1'b0;
        @(negedge DCLK);
        chk("rd_do_hold", 32'(DO), 32'(m_mem[a]));
        chk("rd_drdy_idle", 32'(DRDY), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  a;
        logic [15:0] d;
        RST = 1'b0; PWRDWN = 1'b0; DEN = 1'b0; DWE = 1'b0;
        DADDR = '0; DI = '0; vco_period_1000 = 33'd32000;
        for (int i = 0; i < 128; i++) m_mem[i] = 16'h0000;

        // Reset state
        @(negedge DCLK);
        @(negedge DCLK);
        chk("reset_do", 32'(DO), 32'd0);
        chk("reset_drdy", 32'(DRDY), 32'd1);
        chk("reset_div0", CLKOUT0_DIVIDE, 32'd128);
        chk("reset_duty0", CLKOUT0_DUTY_CYCLE_1000, 32'd500);
        chk("reset_mult", CLKFBOUT_MULT, 32'd128);
        chk("reset_divclk", DIVCLK_DIVIDE, 32'd128);
        check_all();
        RST = 1'b1;
        @(negedge DCLK);
        chk("release_drdy", 32'(DRDY), 32'd1);

        // CLKOUT0 Reg1, then read back and decode
        drp_write(7'h08, 16'b011_0_000110_000011, 1'b0);
        drp_read(7'h08, 1'b0);
        chk("step3_do", 32'(DO), 32'h6183);
        chk("step3_div", CLKOUT0_DIVIDE, 32'd9);
        chk("step3_duty", CLKOUT0_DUTY_CYCLE_1000, 32'd667);
        chk("step3_phase", CLKOUT0_PHASE, 32'd12);

        drp_write(7'h09, 16'h0043, 1'b0);
        chk("step4_div", CLKOUT0_DIVIDE, 32'd1);
        chk("step4_duty", CLKOUT0_DUTY_CYCLE_1000, 32'd500);
        chk("step4_phase", CLKOUT0_PHASE, 32'd108);

        // Power-down blocks writes but not reads
        drp_write(7'h16, 16'h0083, 1'b1);
        drp_read(7'h16, 1'b1);
        chk("pwrdwn_do", 32'(DO), 32'h0000);
        drp_write(7'h16, 16'h0083, 1'b0);
        drp_read(7'h16, 1'b0);
        chk("pwrup_do", 32'(DO), 32'h0083);
        chk("divclk_5", DIVCLK_DIVIDE, 32'd5);

        drp_write(7'h14, 16'h0145, 1'b0);
        chk("mult_10", CLKFBOUT_MULT, 32'd10);
        check_all();

        // VCO period reaches the phase outputs without a clock edge
        vco_period_1000 = 33'd40000;
        #1;
        chk("vco_phase0", CLKOUT0_PHASE, 32'd135);
        check_all();

        // Randomized accesses against the reference
        for (int it = 0; it < 150; it++) begin
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(6, 22));
            d = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       drp_read(a, 1'($urandom));
                1:       drp_write(a, d, 1'b1);
                2: begin
                    vco_period_1000 = 33'($urandom_range(1000, 200000));
                    #1;
                end
                default: drp_write(a, d, 1'b0);
            endcase
            check_all();
            if ((it % 10) == 0) drp_read(a, 1'b0);
        end

        // Reset asserted during an access wins
        drp_write(7'h08, 16'hBEEF, 1'b0);
        drp_read(7'h08, 1'b0);
        DADDR = 7'h08; DI = 16'hFFFF; DEN = 1'b1; DWE = 1'b1; RST = 1'b0;
        @(negedge DCLK);
        for (int i = 0; i < 128; i++) m_mem[i] = 16'h0000;
        chk("midrst_do", 32'(DO), 32'd0);
        chk("midrst_drdy", 32'(DRDY), 32'd1);
        chk("midrst_div0", CLKOUT0_DIVIDE, 32'd128);
        RST = 1'b1; DEN = 1'b0; DWE = 1'b0;
        @(negedge DCLK);
        drp_read(7'h08, 1'b0);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
